// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register word addresses,
// edge-type encodings and the synchroniser depth limit.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA_OUT = 3'd0;
    localparam logic [2:0] ADDR_DATA_IN  = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
    localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

endpackage

// File: rtl/pio_edge_sync.sv
// Input conditioning for the PIO: a multi-flop synchroniser per bit, a
// previous-value flop for edge detection, and an arming counter that hides
// the artificial edges seen while the chain fills after reset.
module pio_edge_sync
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    // Depth is clamped to the supported range so the chain slice is always legal
    localparam int STAGES = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES :
                            (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
    localparam int CW = $clog2(STAGES + 2);
    localparam logic [CW-1:0] ARM_COUNT = CW'(STAGES + 1);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]             prev_q;
    logic [CW-1:0]                arm_q;
    logic [CW-1:0]                arm_d;
    logic                         armed;
    logic [WIDTH-1:0]             lastStage;
    logic [WIDTH-1:0]             rawEdge;

    assign lastStage = sync_q[STAGES-1];
    assign sync_o    = lastStage;
    assign armed     = (arm_q == ARM_COUNT);

    // Synchroniser chain, previous-value flop and arming counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
            arm_q  <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], in_i};
            prev_q <= lastStage;
            arm_q  <= arm_d;
        end
    end

    // Counter advances until armed, then holds; edges are masked until then
    always_comb begin
        arm_d   = armed ? arm_q : arm_q + CW'(1);
        rawEdge = lastStage & ~prev_q;
        case (EDGE_TYPE)
            EDGE_FALLING: rawEdge = ~lastStage & prev_q;
            EDGE_ANY:     rawEdge = lastStage ^ prev_q;
            default:      rawEdge = lastStage & ~prev_q;
        endcase
        edge_o = armed ? rawEdge : '0;
    end

endmodule

// File: rtl/avalon_pio_gpio.sv
// Avalon-MM slave PIO: output register with set/clear aliases, synchronised
// input port with per-bit edge capture and a maskable level interrupt.
module avalon_pio_gpio
    import avalon_pio_pkg::*;
#(
    parameter int               WIDTH       = 5,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edgeClear;
    logic [WIDTH-1:0] edgePulse;
    logic [WIDTH-1:0] dataIn;
    logic             unused_writedata;

    assign wr               = chipselect & ~write_n;
    assign wd               = writedata[WIDTH-1:0];
    assign unused_writedata = ^writedata;
    assign out_port         = data_out_q;
    assign irq              = |(edge_cap_q & irq_mask_q);

    pio_edge_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_edge_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .in_i    (in_port),
        .sync_o  (dataIn),
        .edge_o  (edgePulse)
    );

    // Register file update; a detected edge overrides a same-cycle clear
    always_comb begin
        data_out_d = data_out_q;
        irq_mask_d = irq_mask_q;
        edgeClear  = '0;
        if (wr) begin
            case (address)
                ADDR_DATA_OUT: data_out_d = wd;
                ADDR_IRQ_MASK: irq_mask_d = wd;
                ADDR_EDGE_CAP: edgeClear  = wd;
                ADDR_OUT_SET:  data_out_d = data_out_q | wd;
                ADDR_OUT_CLR:  data_out_d = data_out_q & ~wd;
                default:       ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~edgeClear) | edgePulse;
    end

    // Register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= RESET_VALUE;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            data_out_q <= data_out_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // Zero-latency read mux, zero-extended; write-only and reserved words read 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA_OUT: readdata[WIDTH-1:0] = data_out_q;
            ADDR_DATA_IN:  readdata[WIDTH-1:0] = dataIn;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = edge_cap_q;
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// Directed bench for avalon_pio_gpio: a 5-bit instance with reset value 0x15
// covering the register map, edge capture and irq, plus a 32-bit instance
// for the top-bit set alias.
module tb_avalon_pio_gpio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [4:0]  in_port;
    logic [4:0]  out_port;
    logic        irq;

    logic [2:0]  address32;
    logic        chipselect32;
    logic        writeN32;
    logic [31:0] writedata32;
    logic [31:0] readdata32;
    logic [31:0] inPort32;
    logic [31:0] outPort32;
    logic        irq32;

    int errorCount = 0;
    int checkCount = 0;

    avalon_pio_gpio #(
        .WIDTH       (5),
        .RESET_VALUE (5'h15),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    avalon_pio_gpio #(
        .WIDTH       (32),
        .RESET_VALUE (32'h0),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (2)
    ) dut32 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address32),
        .chipselect (chipselect32),
        .write_n    (writeN32),
        .writedata  (writedata32),
        .readdata   (readdata32),
        .in_port    (inPort32),
        .out_port   (outPort32),
        .irq        (irq32)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One-cycle write on the 5-bit instance, bus returned to idle afterwards
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = addr;
        writedata  = data;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ticks(3);
        reset_n = 1'b1;
        tick();
        checkCount++;
        if (out_port !== 5'h15) begin
            errorCount++;
            $display("[TB] FAIL reset_out_port: got %h want 15", out_port);
        end
        address = 3'd0; #1;
        checkCount++;
        if (readdata !== 32'h15) begin
            errorCount++;
            $display("[TB] FAIL reset_read_data_out: got %h want 00000015", readdata);
        end
        address = 3'd2; #1;
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_read_irq_mask: got %h want 0", readdata);
        end
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL reset_read_edge_cap: got %h want 0", readdata);
        end
        checkCount++;
        if (irq !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_irq: got %b want 0", irq);
        end
        ticks(5);
    endtask

    task automatic test_back_to_back();
        applyStimulus(3'd4, 32'h03);
        checkCount++;
        if (out_port !== 5'h17) begin
            errorCount++;
            $display("[TB] FAIL out_set: got %h want 17", out_port);
        end
        applyStimulus(3'd5, 32'h10);
        checkCount++;
        if (out_port !== 5'h07) begin
            errorCount++;
            $display("[TB] FAIL out_clr: got %h want 07", out_port);
        end
        chipselect = 1'b0;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h1F;
        tick();
        write_n = 1'b1;
        checkCount++;
        if (out_port !== 5'h07) begin
            errorCount++;
            $display("[TB] FAIL cs_low_write_ignored: got %h want 07", out_port);
        end
        applyStimulus(3'd6, 32'h1F);
        checkCount++;
        if (out_port !== 5'h07) begin
            errorCount++;
            $display("[TB] FAIL reserved_write_ignored: got %h want 07", out_port);
        end
    endtask

    task automatic test_registers();
        applyStimulus(3'd0, 32'hFFFF_FFEA);
        checkCount++;
        if (out_port !== 5'h0A) begin
            errorCount++;
            $display("[TB] FAIL data_out_replace: got %h want 0A", out_port);
        end
        address = 3'd0; #1;
        checkCount++;
        if (readdata !== 32'h0000_000A) begin
            errorCount++;
            $display("[TB] FAIL data_out_readback: got %h want 0000000a", readdata);
        end
        applyStimulus(3'd2, 32'h04);
        address = 3'd2; #1;
        checkCount++;
        if (readdata !== 32'h04) begin
            errorCount++;
            $display("[TB] FAIL irq_mask_readback: got %h want 00000004", readdata);
        end
        for (int a = 4; a < 8; a++) begin
            address = 3'(a); #1;
            checkCount++;
            if (readdata !== 32'h0) begin
                errorCount++;
                $display("[TB] FAIL read_addr%0d_zero: got %h want 0", a, readdata);
            end
        end
    endtask

    task automatic test_data_in();
        in_port = 5'h09;
        address = 3'd1;
        tick();
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL data_in_one_stage: got %h want 0", readdata);
        end
        tick();
        checkCount++;
        if (readdata !== 32'h09) begin
            errorCount++;
            $display("[TB] FAIL data_in_synced: got %h want 00000009", readdata);
        end
        in_port = 5'h00;
        ticks(4);
        applyStimulus(3'd3, 32'h1F);
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL edge_cap_clear_all: got %h want 0", readdata);
        end
    endtask

    task automatic test_edge_irq();
        address = 3'd3;
        in_port = 5'h04;
        ticks(2);
        checkCount++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL edge_too_early: got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
        end
        tick();
        checkCount++;
        if (readdata !== 32'h04) begin
            errorCount++;
            $display("[TB] FAIL edge_cap_latency: got %h want 00000004", readdata);
        end
        checkCount++;
        if (irq !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL irq_rise: got %b want 1", irq);
        end
    endtask

    task automatic test_edge_clear();
        applyStimulus(3'd3, 32'h01);
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h04) begin
            errorCount++;
            $display("[TB] FAIL clear_other_bit: got %h want 00000004", readdata);
        end
        applyStimulus(3'd3, 32'h04);
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h0 || irq !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL clear_bit2: got cap=%h irq=%b want cap=0 irq=0", readdata, irq);
        end
        in_port = 5'h00;
        ticks(4);
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL falling_ignored: got %h want 0", readdata);
        end
        in_port = 5'h04;
        ticks(2);
        applyStimulus(3'd3, 32'h04);
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h04 || irq !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL set_wins_over_clear: got cap=%h irq=%b want cap=04 irq=1", readdata, irq);
        end
    endtask

    task automatic test_reset_held();
        logic sawCapture;
        sawCapture = 1'b0;
        in_port = 5'h1F;
        reset_n = 1'b0;
        ticks(2);
        reset_n = 1'b1;
        address = 3'd3; #1;
        checkCount++;
        if (readdata !== 32'h0 || irq !== 1'b0 || out_port !== 5'h15) begin
            errorCount++;
            $display("[TB] FAIL mid_reset_clear: got cap=%h irq=%b out=%h want 0 0 15", readdata, irq, out_port);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (readdata !== 32'h0) sawCapture = 1'b1;
        end
        checkCount++;
        if (sawCapture !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL static_input_after_reset: got capture=%b want 0", sawCapture);
        end
        in_port = 5'h1E;
        ticks(4);
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL bit0_fall_ignored: got %h want 0", readdata);
        end
        in_port = 5'h1F;
        ticks(2);
        checkCount++;
        if (readdata !== 32'h0) begin
            errorCount++;
            $display("[TB] FAIL bit0_rise_early: got %h want 0", readdata);
        end
        tick();
        checkCount++;
        if (readdata !== 32'h01) begin
            errorCount++;
            $display("[TB] FAIL bit0_rise_capture: got %h want 00000001", readdata);
        end
    endtask

    task automatic test_width32();
        chipselect32 = 1'b1;
        writeN32     = 1'b0;
        address32    = 3'd4;
        writedata32  = 32'h8000_0000;
        tick();
        chipselect32 = 1'b0;
        writeN32     = 1'b1;
        address32    = 3'd0; #1;
        checkCount++;
        if (outPort32[31] !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL w32_out_port_msb: got %b want 1", outPort32[31]);
        end
        checkCount++;
        if (readdata32 !== 32'h8000_0000) begin
            errorCount++;
            $display("[TB] FAIL w32_readback: got %h want 80000000", readdata32);
        end
    endtask

    // Test sequence
    initial begin
        reset_n      = 1'b0;
        address      = 3'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'h0;
        in_port      = 5'h00;
        address32    = 3'd0;
        chipselect32 = 1'b0;
        writeN32     = 1'b1;
        writedata32  = 32'h0;
        inPort32     = 32'h0;
        #2;
        test_reset();
        test_back_to_back();
        test_registers();
        test_data_in();
        test_edge_irq();
        test_edge_clear();
        test_reset_held();
        test_width32();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
